// File: rtl/athos_ip_pkg.sv
// athos_ip_pkg: shared LSU state type, operation codes and per-operation word budgets.
package athos_ip_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} lsu_state_e;
  localparam logic [5:0] OP_NULL   = 6'd0;
  localparam logic [5:0] OP_NTT    = 6'd1;
  localparam logic [5:0] OP_INTT   = 6'd2;
  localparam logic [5:0] OP_KECCAK = 6'd3;
  localparam logic [5:0] OP_TRNG   = 6'd4;
  localparam int LSU_NTT_WORDS    = 256;
  localparam int LSU_KECCAK_WORDS = 25;
  localparam int LSU_TRNG_WORDS   = 16;
  function automatic logic [8:0] lsu_budget(input logic [5:0] op, input logic is_load);
    return (op == OP_NTT || op == OP_INTT) ? 9'(LSU_NTT_WORDS) :
           (op == OP_KECCAK) ? 9'(LSU_KECCAK_WORDS) :
           (op == OP_TRNG && !is_load) ? 9'(LSU_TRNG_WORDS) : 9'd0;
  endfunction
endpackage

// File: rtl/athos_ip_lsu_fifo.sv
// athos_ip_lsu_fifo: power-of-two synchronous FIFO; a pop of a non-empty FIFO frees room for a same-cycle push.
module athos_ip_lsu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == FULL_CNT;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/athos_ip_lsu.sv
// athos_ip_lsu: streams bus words into the datapath (LOAD) and datapath results back onto the bus (STORE/DRAIN).
// Define ATHOS_IP_LSU_ERR_EN to accept-and-drop stray writes outside LOAD and flag them on a sticky err_o.
module athos_ip_lsu
  import athos_ip_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [5:0]  operation_i,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic        load_en_o,
  output logic [31:0] load_data_o,
  output logic        store_req_o,
  input  logic [31:0] dp_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LAST_FREE = (AW+1)'(FIFO_DEPTH - 1);
  lsu_state_e state, state_n;
  logic [8:0] budget, cnt, ld_budget, st_budget;
  logic ld_go, st_go, ld_wready, ld_last, drain_done, inflight, done_q;
  logic wf_push, wf_full, wf_empty, rf_full, rf_empty;
  logic [AW:0] wf_count, rf_count;
  logic [31:0] wf_rdata, rf_rdata;
  assign ld_budget = lsu_budget(operation_i, 1'b1);
  assign st_budget = lsu_budget(operation_i, 1'b0);
  assign ld_go = state == IDLE && load_i && ld_budget != '0;
  assign st_go = state == IDLE && !ld_go && store_i && st_budget != '0;
  assign ld_wready = !wf_full && cnt < budget;
  assign wf_push = state == LOAD && wvalid_i && ld_wready;
  assign load_en_o = state == LOAD && !wf_empty;
  assign load_data_o = load_en_o ? wf_rdata : '0;
  // Once every word is accepted, the last one still queued is the final pop.
  assign ld_last = load_en_o && cnt == budget && wf_count == (AW+1)'(1);
  // In-flight result needs a free slot too, so at most FIFO_DEPTH results are ever outstanding.
  assign store_req_o = state == STORE && cnt < budget && !rf_full && !(inflight && rf_count == LAST_FREE);
  assign rvalid_o = !rf_empty;
  assign rdata_o = rvalid_o ? rf_rdata : '0;
  assign drain_done = state == DRAIN && rf_empty && !inflight;
  assign busy_o = state != IDLE;
  assign done_o = done_q;
`ifdef ATHOS_IP_LSU_ERR_EN
  logic err_q;
  assign wready_o = state == LOAD ? ld_wready : 1'b1;
  assign err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) err_q <= 1'b0;
    else if (wvalid_i && state != LOAD) err_q <= 1'b1;
`else
  assign wready_o = state == LOAD && ld_wready;
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = ld_go ? LOAD : st_go ? STORE : IDLE;
      LOAD:    state_n = ld_last ? IDLE : LOAD;
      STORE:   state_n = (store_req_o && cnt == budget - 9'd1) ? DRAIN : STORE;
      DRAIN:   state_n = drain_done ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state    <= IDLE;
      budget   <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      budget   <= ld_go ? ld_budget : st_go ? st_budget : budget;
      cnt      <= (ld_go || st_go) ? '0 : (wf_push || store_req_o) ? cnt + 9'd1 : cnt;
      inflight <= store_req_o;
      done_q   <= ld_last || drain_done;
    end
  athos_ip_lsu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(wf_push), .pop(load_en_o), .wdata(wdata_i),
    .rdata(wf_rdata), .full(wf_full), .empty(wf_empty), .count(wf_count)
  );
  athos_ip_lsu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rfifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(inflight), .pop(rvalid_o && rready_i), .wdata(dp_data_i),
    .rdata(rf_rdata), .full(rf_full), .empty(rf_empty), .count(rf_count)
  );
endmodule

// File: tb/tb_athos_ip_lsu.sv
// tb_athos_ip_lsu: randomized load/store traffic with a queue scoreboard checked by an independent monitor.
module tb_athos_ip_lsu;
  import athos_ip_pkg::*;
  localparam int D = 4;
  logic clk = 0, rst_ni = 0, load_i = 0, store_i = 0, wvalid_i = 0, rready_i = 0;
  logic [5:0] operation_i = '0;
  logic [31:0] wdata_i = '0, dp_data_i = '0;
  logic wready_o, rvalid_o, load_en_o, store_req_o, busy_o, done_o, err_o;
  logic [31:0] rdata_o, load_data_o;
  int vecs = 0, errs = 0;
  int n_ld = 0, n_req = 0, n_rd = 0, n_done = 0;
  bit req_seen = 0;
  logic [31:0] exp_ld[$], exp_rd[$];

  athos_ip_lsu #(.FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .load_i(load_i), .store_i(store_i), .operation_i(operation_i),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .load_en_o(load_en_o), .load_data_o(load_data_o),
    .store_req_o(store_req_o), .dp_data_i(dp_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctrl"}, 32'({load_en_o, store_req_o, rvalid_o, busy_o, done_o, err_o}), 0);
    chk({name, "_load_data"}, load_data_o, 0);
    chk({name, "_rdata"}, rdata_o, 0);
`ifndef ATHOS_IP_LSU_ERR_EN
    chk({name, "_wready"}, 32'(wready_o), 0);
`endif
  endtask

  // Monitor: consumes the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    req_seen = rst_ni && store_req_o;
    if (rst_ni) begin
      if (load_en_o) begin
        n_ld++;
        if (exp_ld.size() == 0) chk("load_unexpected", 1, 0);
        else chk("load_data", load_data_o, exp_ld.pop_front());
      end
      if (store_req_o) begin
        n_req++;
        chk("outstanding_le_depth", 32'(n_req - n_rd <= D), 1);
      end
      if (rvalid_o && rready_i) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rdata", rdata_o, exp_rd.pop_front());
        n_rd++;
      end
      if (done_o) n_done++;
    end
  end

  // Datapath model: answers each request with a fresh random word one cycle later.
  always @(posedge clk) begin
    #1;
    if (rst_ni && req_seen) begin
      dp_data_i = $urandom;
      exp_rd.push_back(dp_data_i);
    end
  end

  task automatic do_load(input logic [5:0] op, input bit both, input bit gaps, input int abort_at);
    int sent = 0, t = 0, d0 = n_done, l0 = n_ld;
    bit hs;
    load_i = 1; store_i = both; operation_i = op;
    cyc;
    load_i = 0; store_i = 0; operation_i = 6'($urandom_range(0, 4));
    chk("busy_after_load_cmd", 32'(busy_o), 1);
    chk("wready_in_load", 32'(wready_o), 1);
    if (both) chk("no_store_req_when_both", 32'(store_req_o), 0);
    wdata_i = $urandom;
    while (sent < LSU_NTT_WORDS && t < 5000) begin
      wvalid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = wvalid_i && wready_o;
      cyc;
      t++;
      if (hs) begin
        exp_ld.push_back(wdata_i);
        sent++;
        wdata_i = $urandom;
      end
      if (abort_at > 0 && sent == abort_at) begin
        #2 rst_ni = 0;
        #1 chk_zero("mid_load_reset");
        exp_ld.delete();
        wvalid_i = 0;
        repeat (2) cyc;
        @(negedge clk) rst_ni = 1;
        cyc;
        return;
      end
    end
    wvalid_i = 0;
    chk("load_words_accepted", sent, LSU_NTT_WORDS);
    t = 0;
    while (n_done == d0 && t < 100) begin cyc; t++; end
    chk("load_done_seen", n_done - d0, 1);
    chk("load_en_pulses", n_ld - l0, LSU_NTT_WORDS);
    chk("busy_low_after_load", 32'(busy_o), 0);
    chk("load_queue_drained", exp_ld.size(), 0);
    repeat (4) cyc;
    chk("load_done_once", n_done - d0, 1);
  endtask

  task automatic do_store(input logic [5:0] op, input int n, input int mode);
    int t = 0, r0 = n_req, rd0 = n_rd, d0 = n_done;
    store_i = 1; operation_i = op; rready_i = (mode == 0);
    cyc;
    store_i = 0; operation_i = OP_NTT;
    chk("busy_after_store_cmd", 32'(busy_o), 1);
    if (mode == 2) begin
      rready_i = 0;
      repeat (20) cyc;
      chk("req_stall_at_depth", n_req - r0, D);
      chk("no_rd_while_stalled", n_rd - rd0, 0);
    end
    while (n_done == d0 && t < 3000) begin
      rready_i = mode == 0 ? ~rready_i : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc;
      t++;
    end
    rready_i = 0;
    chk("store_req_count", n_req - r0, n);
    chk("store_rd_count", n_rd - rd0, n);
    chk("store_done_seen", n_done - d0, 1);
    chk("busy_low_after_store", 32'(busy_o), 0);
    chk("store_queue_drained", exp_rd.size(), 0);
    repeat (4) cyc;
    chk("store_done_once", n_done - d0, 1);
    chk("no_extra_req", n_req - r0, n);
  endtask

  task automatic zero_budget(input bit is_load, input logic [5:0] op);
    int d0 = n_done;
    load_i = is_load; store_i = !is_load; operation_i = op;
    cyc;
    load_i = 0; store_i = 0;
    chk("zero_budget_idle", 32'(busy_o), 0);
    repeat (3) cyc;
    chk("zero_budget_no_done", n_done - d0, 0);
  endtask

  initial begin
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_ni = 1;
    cyc;
    do_load(OP_NTT, 0, 0, 0);
    do_load(OP_INTT, 0, 1, 0);
    do_store(OP_KECCAK, LSU_KECCAK_WORDS, 0);
    do_store(OP_TRNG, LSU_TRNG_WORDS, 2);
    do_store(OP_KECCAK, LSU_KECCAK_WORDS, 1);
    do_load(OP_NTT, 1, 0, 0);
    zero_budget(1, OP_TRNG);
    zero_budget(1, OP_NULL);
    zero_budget(0, OP_NULL);
    zero_budget(0, 6'd9);
    wvalid_i = 1; wdata_i = 32'hdead_beef;
    @(negedge clk);
`ifdef ATHOS_IP_LSU_ERR_EN
    chk("idle_write_wready", 32'(wready_o), 1);
`else
    chk("idle_write_wready", 32'(wready_o), 0);
`endif
    cyc;
    wvalid_i = 0;
    @(negedge clk);
`ifdef ATHOS_IP_LSU_ERR_EN
    chk("idle_write_err", 32'(err_o), 1);
`else
    chk("idle_write_err", 32'(err_o), 0);
`endif
    cyc;
    do_load(OP_KECCAK, 0, 0, 20);
    chk("err_cleared_by_reset", 32'(err_o), 0);
    do_load(OP_NTT, 0, 0, 100);
    do_load(OP_NTT, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/athos_ip_lsu.md
ATHOS_IP_LSU -- requirements
Module: athos_ip_lsu

Interface
REQ-001 Parameter FIFO_DEPTH, 4, entries per direction FIFO; power of two, >=2.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 load_i / store_i  in  1 / 1  command pulses, same as control unit receives.
REQ-005 operation_i  in  6  operation code (athos_ip_pkg encoding).
REQ-006 wdata_i / wvalid_i / wready_o  in 32 / in 1 / out 1  bus write stream.
REQ-007 rdata_o / rvalid_o / rready_i  out 32 / out 1 / in 1  bus read stream.
REQ-008 load_en_o / load_data_o  out 1 / out 32  word to datapath; feeds control unit load_en.
REQ-009 store_req_o / dp_data_i  out 1 / in 32  datapath result read, fixed 1-cycle latency.
REQ-010 busy_o / done_o  out 1 / out 1  transfer active; 1-cycle completion pulse.
REQ-011 err_o  out 1  sticky protocol error (see REQ-030).

Function
REQ-012 FSM states IDLE_LD_S... shall be IDLE, LOAD, STORE, DRAIN.
REQ-013 Word budget: NTT/INTT 256, KECCAK 25, TRNG 0 for load / 16 for store; NULL and other codes 0.
REQ-014 IDLE: load_i with nonzero budget -> LOAD; else store_i with nonzero budget -> STORE; both asserted -> load wins; zero budget -> stay IDLE, no done_o.
REQ-015 Budget latched at command acceptance; operation_i changes afterward ignored.
REQ-016 Commands outside IDLE ignored.
REQ-017 LOAD: wready_o = FIFO not full and accepted-word count < budget; wvalid_i&wready_o pushes word.
REQ-018 LOAD: load_en_o asserted every cycle FIFO non-empty, load_data_o = head, popped same cycle; no back-pressure from datapath.
REQ-019 Word accepted in cycle N appears on load_en_o in cycle N+1 at earliest.
REQ-020 Simultaneous push and pop on full or empty FIFO both legal, occupancy unchanged/consistent.
REQ-021 After budget-th pop: done_o pulses next cycle, state -> IDLE.
REQ-022 STORE: store_req_o asserted only if FIFO free entries minus in-flight requests >=1 and issued count < budget.
REQ-023 dp_data_i sampled cycle after store_req_o, pushed into read FIFO; rvalid_o = read FIFO non-empty; pop on rvalid_o&rready_i.
REQ-024 After budget-th request issued -> DRAIN; DRAIN ends when read FIFO empty and no request in flight: done_o pulse, -> IDLE.
REQ-025 busy_o = state != IDLE.
REQ-026 Counters 9 bits, never wrap; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 In IDLE: wready_o, load_en_o, store_req_o, rvalid_o low unless REQ-030 applies.

Reset
REQ-028 rst_ni low: state IDLE, FIFOs empty, counters 0, all outputs 0, err_o cleared, immediately and asynchronously, including mid-transfer; partial data discarded.
REQ-029 First command accepted on first clock edge after rst_ni deasserts.

Configuration
REQ-030 Macro ATHOS_IP_LSU_ERR_EN defined: wready_o high in IDLE/STORE/DRAIN, write accepted there is dropped and sets err_o until reset; not defined: wready_o low outside LOAD (writes stall), err_o tied 0.

Structure
REQ-031 athos_ip_pkg shall hold lsu state typedef and budget constants (LSU_NTT_WORDS=256, LSU_KECCAK_WORDS=25, LSU_TRNG_WORDS=16).
REQ-032 One sub-module athos_ip_lsu_fifo (parameterised width/depth, push/pop/full/empty), instantiated twice.

Verification
REQ-033 NTT load, 256 back-to-back writes -> 256 load_en_o pulses, data in order, done_o at cycle after last pop, busy_o low next.
REQ-034 KECCAK store, rready_i toggling 1/0 -> exactly 25 store_req_o, never >FIFO_DEPTH outstanding, 25 ordered rdata_o, done_o once.
REQ-035 Store with rready_i held low -> store_req_o stops after FIFO_DEPTH requests; releases resume without loss.
REQ-036 load_i and store_i same cycle, NTT -> LOAD entered, store ignored.
REQ-037 rst_ni asserted at word 100 of NTT load -> all outputs 0 same cycle; new load succeeds with 256 words.
REQ-038 Write in IDLE: with ATHOS_IP_LSU_ERR_EN err_o=1 and word dropped; without, wready_o=0 and err_o=0.
